// File: rtl/fetch_queue_if.sv
// Signal bundle for fetch_queue: instruction-memory port, decode handshake, redirect and perf counters.
// The master modport is the fetch queue; the slave modport is the memory/decode environment.
interface fetch_queue_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
);
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_npc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [15:0]        fetch_cnt;
  logic [15:0]        flush_cnt;

  modport master (
    output imem_en, imem_addr, out_valid, out_instr, out_npc, fetch_cnt, flush_cnt,
    input  imem_rdata, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_en, imem_addr, out_valid, out_instr, out_npc, fetch_cnt, flush_cnt,
    output imem_rdata, out_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: PC register, 1-cycle-latency imem reads, DEPTH-entry {instr, npc} FIFO, redirect flush.
// Optional perf counters (fetch_cnt/flush_cnt) are built only when FETCH_PERF_EN is defined.
module fetch_queue #(
  parameter int               ADDR_W   = 8,
  parameter int               INSTR_W  = 32,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               inflight_q, inflight_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  npc_mem_q [DEPTH];
  logic [OCC_W-1:0]   occupancy;
  logic               issue;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Counting the outstanding read guarantees its data always finds a free slot.
  assign pop       = (count_q != '0) & bus.out_ready & ~bus.redirect;
  assign push      = inflight_q & ~bus.redirect;
  assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign issue     = ~reset & ~bus.redirect & (occupancy < DEPTH_OCC);

  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inflight_d = issue;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect) begin
      pc_d     = bus.redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) begin
        pc_d       = pc_q + ADDR_W'(1);
        req_addr_d = pc_q;
      end
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
      npc_mem_q[wr_ptr_q]   <= req_addr_q + ADDR_W'(1);
    end
  end

  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = instr_mem_q[rd_ptr_q];
  assign bus.out_npc   = npc_mem_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pop && fetch_cnt_q != 16'hFFFF)          fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (bus.redirect && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.fetch_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the processor's fixed single-slot fetch stage (PC register + IF/ID latch).
- Drives a synchronous instruction memory with 1-cycle read latency and buffers fetched words in a DEPTH-entry FIFO.
- Hands the decode stage instruction plus next-PC over a valid/ready handshake.
- Accepts branch/jump redirects that flush the queue and the in-flight read.

Parameters:
ADDR_W, 8, PC / instruction-memory word-address width
INSTR_W, 32, instruction width
DEPTH, 4, FIFO entries; legal range 2..16; any value in range sustains 1 instr/cycle
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high
imem_en  output  1  read request this cycle
imem_addr  output  ADDR_W  read word address (= pc register)
imem_rdata  input  INSTR_W  read data, valid the cycle after the request
out_valid  output  1  head FIFO entry available
out_ready  input  1  decode accepts head entry
out_instr  output  INSTR_W  head instruction
out_npc  output  ADDR_W  head instruction address + 1
redirect  input  1  flush and refetch from redirect_pc
redirect_pc  input  ADDR_W  new fetch address
fetch_cnt  output  16  instructions delivered (see Optional Feature)
flush_cnt  output  16  redirects taken (see Optional Feature)

Behaviour:
- Interface decision: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values (clocked edge with reset=1):
  - pc = RESET_PC; FIFO count = 0; rd/wr pointers = 0; inflight = 0.
  - out_valid = 0; imem_en = 0 while reset is high; counters = 0.
- State: pc reg, inflight flag (1 bit; at most one read outstanding), FIFO storage {instr, npc}, count 0..DEPTH.
- pop = out_valid & out_ready & ~redirect.
- Issue rule: imem_en = ~reset & ~redirect & (count + inflight - pop < DEPTH).
  - On issue, pc <= pc + 1 (mod 2^ADDR_W; 0xFF wraps to 0x00 for ADDR_W=8).
  - On issue, inflight <= 1, and the request's address is captured as req_addr.
  - With no issue, inflight <= 0.
- Response: when inflight=1 and redirect=0, push {imem_rdata, req_addr+1} at the edge ending that cycle.
  - The push/issue rule guarantees a push never meets a full FIFO.
  - Verification asserts "no push when count==DEPTH".
- out_valid = (count != 0). out_instr/out_npc come from the head entry, read combinationally from the register array.
- Simultaneous push and pop: count unchanged, both pointers advance. Push into empty FIFO: visible next cycle; no same-cycle bypass.
- Redirect (cycle t), highest priority:
  - count <= 0, pointers <= 0, inflight <= 0.
  - Any data returning in cycle t is discarded.
  - pc <= redirect_pc.
  - No issue and no pop in cycle t.
  - Outcome: t+1 imem_en=1 with imem_addr=redirect_pc; t+2 data; t+3 out_valid=1.
- Redirect during reset: reset wins.
- Redirect asserted on consecutive cycles: the last one wins; issue resumes the cycle after redirect drops.
- Reset mid-operation: all state returns to reset values at that edge; in-flight data is discarded.
- Startup latency: first cycle with reset low is cycle 0 (imem_en=1, addr=RESET_PC); out_valid=1 in cycle 2.
- Steady state with out_ready=1: one instruction per cycle.
- out_ready=0 for long: queue fills to DEPTH, then imem_en=0 and pc holds. No instruction is lost or duplicated.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - fetch_cnt increments on each pop.
  - flush_cnt increments on each cycle with redirect=1 and reset=0.
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: counter logic is removed; fetch_cnt and flush_cnt are tied to 0.

Test Plan:
1. Reset, then out_ready=1, imem_rdata = addr ^ 0xA5A5_0000 → imem_addr sequence 0x00,0x01,…; out_valid from cycle 2; out_instr=0xA5A5_0000 with out_npc=0x01, then one instr per cycle.
2. out_ready=0 for 10 cycles after reset → exactly DEPTH=4 entries held; imem_en=0 and imem_addr=0x04 hold; releasing out_ready delivers addresses 0..3, then 4 with no gap beyond refill latency.
3. Redirect to 0x40 while 3 entries are queued and a read is in flight → next cycle count=0, imem_addr=0x40; first delivered out_npc=0x41; stale entries never appear.
4. Redirect asserted in the same cycle as out_valid&out_ready → no pop counted; with FETCH_PERF_EN, fetch_cnt unchanged and flush_cnt +1.
5. RESET_PC=0xFE, free-running → addresses 0xFE,0xFF,0x00,0x01; out_npc of 0xFF entry is 0x00.
6. Assert reset for one cycle mid-stream with 2 entries queued → next cycle out_valid=0, imem_en=1, imem_addr=RESET_PC, counters 0.
